sar_cmp_responder: RTL and testbench

Synthesizable comparator/DAC responder for the 8-bit SAR conversion engine. It is the analog-side counterpart of the SAR controller: it holds a sampled input code and answers each trial code the controller drives with a comparator bit. When the controller signals done, it checks the final code against the held value and keeps conversion and error statistics. It sits beside the SAR top in self-test builds and on the bench, wired controller `uo_out` → `trial`, controller `uio_out[0]` → `done`, `cmp` → controller `ui_in[0]`.

---
 rtl/sar_pkg.sv | 16 +
 rtl/sar_cmp_responder_if.sv | 36 +++
 rtl/sar_cmp_pipe.sv | 44 ++++
 rtl/sar_cmp_responder.sv | 97 +++++++++
 tb/tb_sar_cmp_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR comparator/DAC responder.
//   SAR_WIDTH       : code width of the conversion engine
//   SAR_CNT_W       : width of the conversion/error statistics counters
//   sar_rsp_state_t : responder FSM state encoding
package sar_pkg;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    CHECK   = 2'd2
  } sar_rsp_state_t;

endpackage

// File: rtl/sar_cmp_responder_if.sv
// Signal bundle between the SAR controller side (master) and the
// comparator/DAC responder (slave).
//   vin, sample         : emulated analog input code and its capture strobe
//   trial, done         : trial code and conversion-complete flag from the controller
//   cmp                 : comparator answer (hold >= trial)
//   busy                : conversion in progress
//   res_ok, res_err     : one-cycle final-code verdict
//   conv_cnt, err_cnt   : saturating statistics
interface sar_cmp_responder_if
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
);

  logic [WIDTH-1:0]     vin;
  logic                 sample;
  logic [WIDTH-1:0]     trial;
  logic                 done;
  logic                 cmp;
  logic                 busy;
  logic                 res_ok;
  logic                 res_err;
  logic [SAR_CNT_W-1:0] conv_cnt;
  logic [SAR_CNT_W-1:0] err_cnt;

  modport master (
    output vin, sample, trial, done,
    input  cmp, busy, res_ok, res_err, conv_cnt, err_cnt
  );

  modport slave (
    input  vin, sample, trial, done,
    output cmp, busy, res_ok, res_err, conv_cnt, err_cnt
  );

endinterface

// File: rtl/sar_cmp_pipe.sv
// Comparator delay line: DEPTH single-bit stages with synchronous flush.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : clears every stage on the next edge (wins over d_i)
//   d_i        : comparator result entering the line
//   q_o        : oldest stage, drives the responder's cmp output
module sar_cmp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stage_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
        end else if (flush_i) begin
          stage_q <= '0;
        end else begin
          stage_q <= d_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
        end else if (flush_i) begin
          stage_q <= '0;
        end else begin
          stage_q <= {stage_q[DEPTH-2:0], d_i};
        end
      end
    end
  endgenerate

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sar_cmp_responder.sv
// Analog-side counterpart of the SAR controller: holds a sampled input
// code, answers trial codes with a comparator bit and grades the final code.
//   clk, rst_n : clock, async active-low reset
//   bus        : responder side of sar_cmp_responder_if (see interface header)
//
// state   | meaning
// IDLE    | waiting for sample; cmp and busy low, done ignored
// CONVERT | comparing hold against trial every cycle; busy high
// CHECK   | single cycle presenting res_ok/res_err for the final code
module sar_cmp_responder
  import sar_pkg::*;
#(
  parameter int WIDTH   = SAR_WIDTH,
  parameter int CMP_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  sar_cmp_responder_if.slave  bus
);

  localparam logic [SAR_CNT_W-1:0] CNT_MAX = '1;

  sar_rsp_state_t       state_q, state_d;
  logic [WIDTH-1:0]     hold_q, final_q;
  logic [SAR_CNT_W-1:0] conv_cnt_q, err_cnt_q;
  logic                 accept_done, capture, flush, cmp_d, mismatch;

  // done has priority over sample in CONVERT; sample is dropped in CHECK.
  assign accept_done = (state_q == CONVERT) && bus.done;
  assign capture     = bus.sample &&
                       ((state_q == IDLE) || ((state_q == CONVERT) && !bus.done));
  // Outside CONVERT the line is held flushed so cmp is already 0 on return to IDLE.
  assign flush       = capture || (state_q != CONVERT);
  assign cmp_d       = (hold_q >= bus.trial);
  assign mismatch    = (bus.trial != hold_q);

  sar_cmp_pipe #(
    .DEPTH (1 + CMP_LAT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .d_i     (cmp_d),
    .q_o     (bus.cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample) state_d = CONVERT;
      CONVERT: if (bus.done)   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == CONVERT);
    bus.res_ok  = (state_q == CHECK) && (final_q == hold_q);
    bus.res_err = (state_q == CHECK) && (final_q != hold_q);
  end

  // Statistics move on the done edge so they are visible together with the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      final_q    <= '0;
      conv_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (capture) begin
        hold_q <= bus.vin;
      end
      if (accept_done) begin
        final_q <= bus.trial;
        if (conv_cnt_q != CNT_MAX) begin
          conv_cnt_q <= conv_cnt_q + 1'b1;
        end
        if (mismatch && (err_cnt_q != CNT_MAX)) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.conv_cnt = conv_cnt_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sar_cmp_responder.sv
module tb_sar_cmp_responder;

  typedef struct packed {
    int unsigned cyc;
    logic        val;
  } cmp_exp_t;

  typedef struct packed {
    logic       ok;
    logic [7:0] conv;
    logic [7:0] err;
  } res_exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          checks;
  int          failures;

  cmp_exp_t cq0[$];
  cmp_exp_t cq1[$];
  res_exp_t rq0[$];
  res_exp_t rq1[$];

  sar_cmp_responder_if #(.WIDTH(8)) if0 ();
  sar_cmp_responder_if #(.WIDTH(8)) if1 ();

  sar_cmp_responder #(.WIDTH(8), .CMP_LAT(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  sar_cmp_responder #(.WIDTH(8), .CMP_LAT(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trial driven now is sampled on the next edge; result visible 1+CMP_LAT edges on.
  task automatic exp_cmp0(input logic v);
    cmp_exp_t e;
    e.cyc = cyc + 1;
    e.val = v;
    cq0.push_back(e);
  endtask

  task automatic exp_cmp1(input logic v);
    cmp_exp_t e;
    e.cyc = cyc + 3;
    e.val = v;
    cq1.push_back(e);
  endtask

  task automatic exp_res0(input logic ok, input logic [7:0] conv, input logic [7:0] err);
    res_exp_t r;
    r.ok = ok; r.conv = conv; r.err = err;
    rq0.push_back(r);
  endtask

  task automatic exp_res1(input logic ok, input logic [7:0] conv, input logic [7:0] err);
    res_exp_t r;
    r.ok = ok; r.conv = conv; r.err = err;
    rq1.push_back(r);
  endtask

  always @(negedge clk) begin : mon0
    cmp_exp_t e;
    res_exp_t r;
    if (rst_n) begin
      while (cq0.size() > 0 && cq0[0].cyc == cyc) begin
        e = cq0.pop_front();
        check1("dut0_cmp", 32'(if0.cmp), 32'(e.val));
      end
      if (if0.res_ok || if0.res_err) begin
        if (rq0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut0_unexpected_result res_ok=%0b res_err=%0b required=none", if0.res_ok, if0.res_err);
        end else begin
          r = rq0.pop_front();
          check1("dut0_res_ok", 32'(if0.res_ok), 32'(r.ok));
          check1("dut0_res_err", 32'(if0.res_err), 32'(!r.ok));
          check1("dut0_conv_cnt", 32'(if0.conv_cnt), 32'(r.conv));
          check1("dut0_err_cnt", 32'(if0.err_cnt), 32'(r.err));
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    cmp_exp_t e;
    res_exp_t r;
    if (rst_n) begin
      while (cq1.size() > 0 && cq1[0].cyc == cyc) begin
        e = cq1.pop_front();
        check1("dut1_cmp", 32'(if1.cmp), 32'(e.val));
      end
      if (if1.res_ok || if1.res_err) begin
        if (rq1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut1_unexpected_result res_ok=%0b res_err=%0b required=none", if1.res_ok, if1.res_err);
        end else begin
          r = rq1.pop_front();
          check1("dut1_res_ok", 32'(if1.res_ok), 32'(r.ok));
          check1("dut1_res_err", 32'(if1.res_err), 32'(!r.ok));
          check1("dut1_conv_cnt", 32'(if1.conv_cnt), 32'(r.conv));
          check1("dut1_err_cnt", 32'(if1.err_cnt), 32'(r.err));
        end
      end
    end
  end

  task automatic check_all_zero0(input string tag);
    check1({tag, "_cmp"}, 32'(if0.cmp), 0);
    check1({tag, "_busy"}, 32'(if0.busy), 0);
    check1({tag, "_res_ok"}, 32'(if0.res_ok), 0);
    check1({tag, "_res_err"}, 32'(if0.res_err), 0);
    check1({tag, "_conv_cnt"}, 32'(if0.conv_cnt), 0);
    check1({tag, "_err_cnt"}, 32'(if0.err_cnt), 0);
  endtask

  logic [7:0] trials_a[8];
  logic       cmps_a[8];
  logic [7:0] trials_b[4];
  logic       cmps_b[4];
  int         conv_m;
  int         err_m;

  initial begin
    trials_a = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    cmps_a   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    trials_b = '{8'h00, 8'h80, 8'h7F, 8'h00};
    cmps_b   = '{1'b1, 1'b0, 1'b1, 1'b1};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if0.vin = '0; if0.sample = 1'b0; if0.trial = '0; if0.done = 1'b0;
    if1.vin = '0; if1.sample = 1'b0; if1.trial = '0; if1.done = 1'b0;

    // Reset with sample/done toggling: everything stays at 0.
    for (int i = 0; i < 4; i++) begin
      tick();
      if0.sample = i[0];
      if0.done   = ~i[0];
      if0.vin    = 8'(i * 37);
      if0.trial  = 8'(i * 11);
      #1;
      check_all_zero0("in_reset");
    end
    if0.sample = 1'b0; if0.done = 1'b0; if0.vin = '0; if0.trial = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check1("idle_cmp", 32'(if0.cmp), 0);
    check1("idle_busy", 32'(if0.busy), 0);

    // Binary search on hold=A5 with single-cycle comparator latency.
    if0.vin = 8'hA5; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    check1("busy_after_sample", 32'(if0.busy), 1);
    for (int i = 0; i < 8; i++) begin
      if0.trial = trials_a[i];
      exp_cmp0(cmps_a[i]);
      tick();
    end
    if0.trial = 8'hA5; if0.done = 1'b1;
    exp_res0(1'b1, 8'd1, 8'd0);
    tick();
    if0.done = 1'b0;
    check1("busy_in_check", 32'(if0.busy), 0);
    tick();
    check1("cmp_back_in_idle", 32'(if0.cmp), 0);

    // Mismatch: hold 00, final 01.
    if0.vin = 8'h00; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    if0.trial = 8'h01; exp_cmp0(1'b0);
    tick();
    if0.done = 1'b1;
    exp_res0(1'b0, 8'd2, 8'd1);
    tick();
    if0.done = 1'b0;
    tick();

    // Top-of-range compare, and sample arriving during CHECK is dropped.
    if0.vin = 8'hFF; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    if0.trial = 8'hFF; exp_cmp0(1'b1);
    tick();
    if0.trial = 8'h00; exp_cmp0(1'b1);
    tick();
    if0.trial = 8'hFF; if0.done = 1'b1;
    exp_res0(1'b1, 8'd3, 8'd1);
    tick();
    if0.done = 1'b0; if0.sample = 1'b1; if0.vin = 8'h12;
    tick();
    if0.sample = 1'b0;
    check1("sample_in_check_dropped", 32'(if0.busy), 0);

    // sample and done together in CONVERT: done wins, hold stays 10.
    if0.vin = 8'h10; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    if0.trial = 8'h10; exp_cmp0(1'b1);
    tick();
    if0.vin = 8'h20; if0.sample = 1'b1; if0.done = 1'b1;
    exp_res0(1'b1, 8'd4, 8'd1);
    tick();
    if0.sample = 1'b0; if0.done = 1'b0;
    check1("done_beats_sample_busy", 32'(if0.busy), 0);
    tick();

    // done held for 4 cycles: one CHECK only.
    if0.vin = 8'h33; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    if0.trial = 8'h33; if0.done = 1'b1;
    exp_res0(1'b1, 8'd5, 8'd1);
    tick(); tick(); tick(); tick();
    if0.done = 1'b0;
    check1("done_held_conv_cnt", 32'(if0.conv_cnt), 5);
    check1("done_held_busy", 32'(if0.busy), 0);

    // CMP_LAT=2 instance: exact 3-cycle latency, then a mid-stream restart.
    if1.vin = 8'h7F; if1.sample = 1'b1;
    tick();
    if1.sample = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if1.trial = trials_b[i];
      exp_cmp1(cmps_b[i]);
      tick();
    end
    if1.trial = 8'h00; exp_cmp1(1'b0);   // in flight at restart, must be flushed
    tick();
    exp_cmp1(1'b0);
    tick();
    if1.vin = 8'h00; if1.sample = 1'b1; exp_cmp1(1'b0);
    tick();
    if1.sample = 1'b0;
    if1.trial = 8'h00; exp_cmp1(1'b1);
    tick();
    if1.trial = 8'h01; exp_cmp1(1'b0);
    tick();
    if1.done = 1'b1;
    exp_res1(1'b0, 8'd1, 8'd1);
    tick();
    if1.done = 1'b0;
    tick(); tick(); tick(); tick();

    // 300 mismatched conversions: both counters saturate at 255.
    conv_m = 5;
    err_m  = 1;
    for (int i = 0; i < 300; i++) begin
      if0.vin = 8'h00; if0.trial = 8'h01; if0.sample = 1'b1;
      tick();
      if0.sample = 1'b0; if0.done = 1'b1;
      conv_m = (conv_m < 255) ? conv_m + 1 : 255;
      err_m  = (err_m  < 255) ? err_m  + 1 : 255;
      exp_res0(1'b0, 8'(conv_m), 8'(err_m));
      tick();
      if0.done = 1'b0;
      tick();
    end
    check1("sat_conv_cnt", 32'(if0.conv_cnt), 255);
    check1("sat_err_cnt", 32'(if0.err_cnt), 255);

    // Reset mid-conversion: no pulse, counters cleared, later done ignored in IDLE.
    if0.vin = 8'h44; if0.sample = 1'b1;
    tick();
    if0.sample = 1'b0;
    if0.trial = 8'h44;
    tick();
    check1("pre_abort_busy", 32'(if0.busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero0("abort");
    tick();
    rst_n = 1'b1;
    if0.done = 1'b1;
    tick(); tick();
    if0.done = 1'b0;
    tick();
    check1("post_abort_conv_cnt", 32'(if0.conv_cnt), 0);
    check1("post_abort_busy", 32'(if0.busy), 0);
    check1("post_abort_dut1_conv_cnt", 32'(if1.conv_cnt), 0);
    tick(); tick();

    check1("dut0_cmp_pending", cq0.size(), 0);
    check1("dut1_cmp_pending", cq1.size(), 0);
    check1("dut0_res_pending", rq0.size(), 0);
    check1("dut1_res_pending", rq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
